// File: rtl/dffrsnq_bank_init_ctrl_if.sv
// Request/bank bundle between a load requester, the init sequencer and the set/reset flop bank.
// master drives the request and bank readback; slave is the sequencer.
interface dffrsnq_bank_init_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  logic             REQ;
  logic [WIDTH-1:0] PAT;
  logic [WIDTH-1:0] MASK;
  logic [CNTW-1:0]  QUIESCE_CYC;
  logic [CNTW-1:0]  PULSE_CYC;
  logic [CNTW-1:0]  RECOV_CYC;
  logic [WIDTH-1:0] BANK_Q;
  logic [WIDTH-1:0] BANK_SETN;
  logic [WIDTH-1:0] BANK_RN;
  logic             BANK_CLKEN;
  logic             BUSY;
  logic             ACK;
  logic             ERR;

  modport master (
    output REQ, PAT, MASK, QUIESCE_CYC, PULSE_CYC, RECOV_CYC, BANK_Q,
    input  BANK_SETN, BANK_RN, BANK_CLKEN, BUSY, ACK, ERR
  );

  modport slave (
    input  REQ, PAT, MASK, QUIESCE_CYC, PULSE_CYC, RECOV_CYC, BANK_Q,
    output BANK_SETN, BANK_RN, BANK_CLKEN, BUSY, ACK, ERR
  );
endinterface

// File: rtl/dffrsnq_bank_init_ctrl.sv
// Forces a preset pattern into a SETN/RN flop bank with the bank clock frozen, then reads it back.
// Latency Q'+P'+R'+1 cycles from request to ACK; 4-phase REQ/ACK, no new load until REQ drops.
module dffrsnq_bank_init_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic                     CLK,
  input  logic                     RN,
  dffrsnq_bank_init_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    PULSE   = 3'd2,
    RECOVER = 3'd3,
    CHECK   = 3'd4,
    ACKW    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  pulse_len;
  logic [CNTW-1:0]  recov_len;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] mask_q;
  logic             err_q;

  logic [WIDTH-1:0] setn_nxt;
  logic [WIDTH-1:0] rn_nxt;
  logic             clken_nxt;
  logic             busy_nxt;
  logic             ack_nxt;

  logic [WIDTH-1:0] setn_q;
  logic [WIDTH-1:0] rn_q;
  logic             clken_q;
  logic             busy_q;
  logic             ack_q;

  logic             accept;
  logic             cnt_done;
  logic             mismatch;

  assign accept   = (state == IDLE) && bus.REQ;
  // A latched count of 0 behaves like 1, so both 0 and 1 finish on the first cycle.
  assign cnt_done = (cnt <= CNTW'(1));
  assign mismatch = |((bus.BANK_Q ^ pat_q) & mask_q);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.REQ)  state_nxt = QUIESCE;
      QUIESCE: if (cnt_done) state_nxt = PULSE;
      PULSE:   if (cnt_done) state_nxt = RECOVER;
      RECOVER: if (cnt_done) state_nxt = CHECK;
      CHECK:                 state_nxt = ACKW;
      ACKW:    if (!bus.REQ) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Request operands are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt       <= '0;
      pulse_len <= '0;
      recov_len <= '0;
      pat_q     <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        pat_q     <= bus.PAT;
        mask_q    <= bus.MASK;
        pulse_len <= bus.PULSE_CYC;
        recov_len <= bus.RECOV_CYC;
        cnt       <= bus.QUIESCE_CYC;
        err_q     <= 1'b0;
      end else if (state_nxt != state) begin
        case (state_nxt)
          PULSE:   cnt <= pulse_len;
          RECOVER: cnt <= recov_len;
          default: cnt <= cnt;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CNTW'(1);
      end

      if (state == CHECK) begin
        err_q <= mismatch;
      end
    end
  end

  // Outputs are decoded from the next state and registered, so they switch on the transition edge.
  // Set and reset lines use disjoint bit sets (pat & mask vs ~pat & mask), so they never overlap.
  always_comb begin
    setn_nxt  = '1;
    rn_nxt    = '1;
    clken_nxt = 1'b1;
    busy_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    case (state_nxt)
      QUIESCE, RECOVER, CHECK: begin
        clken_nxt = 1'b0;
        busy_nxt  = 1'b1;
      end
      PULSE: begin
        clken_nxt = 1'b0;
        busy_nxt  = 1'b1;
        setn_nxt  = ~(pat_q & mask_q);
        rn_nxt    = ~(~pat_q & mask_q);
      end
      ACKW: begin
        ack_nxt = 1'b1;
      end
      default: begin
        ack_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      setn_q  <= '1;
      rn_q    <= '1;
      clken_q <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      setn_q  <= setn_nxt;
      rn_q    <= rn_nxt;
      clken_q <= clken_nxt;
      busy_q  <= busy_nxt;
      ack_q   <= ack_nxt;
    end
  end

  assign bus.BANK_SETN  = setn_q;
  assign bus.BANK_RN    = rn_q;
  assign bus.BANK_CLKEN = clken_q;
  assign bus.BUSY       = busy_q;
  assign bus.ACK        = ack_q;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_dffrsnq_bank_init_ctrl.sv
// Directed bench for the bank init sequencer with a behavioural SETN/RN bank and an ACK-driven scoreboard.
module tb_dffrsnq_bank_init_ctrl;
  localparam int W = 8;
  localparam int C = 4;

  logic CLK = 1'b0;
  logic RN;
  always #5 CLK = ~CLK;

  dffrsnq_bank_init_ctrl_if #(.WIDTH(W), .CNTW(C)) bus();
  dffrsnq_bank_init_ctrl #(.WIDTH(W), .CNTW(C)) dut (.CLK(CLK), .RN(RN), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural bank: asynchronous active-low set/reset per bit, optional stuck-at-0 readback.
  logic [W-1:0] bank;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] preload_val = '0;
  logic         preload_stb = 1'b0;
  logic         preload_seen = 1'b0;
  logic [W-1:0] model_bank = '0;

  always @(bus.BANK_SETN or bus.BANK_RN or preload_stb) begin
    if (preload_stb != preload_seen) begin
      bank = preload_val;
      preload_seen = preload_stb;
    end
    for (int i = 0; i < W; i++) begin
      if (!bus.BANK_SETN[i])    bank[i] = 1'b1;
      else if (!bus.BANK_RN[i]) bank[i] = 1'b0;
    end
  end
  assign bus.BANK_Q = bank & ~stuck0;

  always @(negedge CLK) begin
    chk("inv_excl", {24'd0, ~bus.BANK_SETN & ~bus.BANK_RN}, 32'd0);
    chk("inv_clken", {31'd0, bus.BANK_CLKEN && ((bus.BANK_SETN != '1) || (bus.BANK_RN != '1))}, 32'd0);
  end

  typedef struct {
    logic [W-1:0] setn;
    logic [W-1:0] rn;
    logic [W-1:0] q;
    logic         err;
    int           ack_at;
    int           pulses;
  } exp_t;
  exp_t sb[$];

  function automatic int mx(input logic [C-1:0] c);
    return (c == '0) ? 1 : int'(c);
  endfunction

  task automatic preload(input logic [W-1:0] v);
    preload_val = v;
    preload_stb = ~preload_stb;
    model_bank  = v;
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] pat, input logic [W-1:0] mask,
                         input logic [C-1:0] q, input logic [C-1:0] p, input logic [C-1:0] r,
                         input int drop_at, input int hold_cyc);
    exp_t e;
    logic [W-1:0] s_seen;
    logic [W-1:0] r_seen;
    int pulses;
    int ack_k;
    bit got;
    e.setn = ~(pat & mask);
    e.rn   = ~(~pat & mask);
    model_bank = (model_bank & ~mask) | (pat & mask);
    e.q      = model_bank & ~stuck0;
    e.err    = |((e.q ^ pat) & mask);
    e.ack_at = mx(q) + mx(p) + mx(r) + 1;
    e.pulses = (mask != '0) ? mx(p) : 0;
    sb.push_back(e);

    @(negedge CLK);
    bus.REQ = 1'b1; bus.PAT = pat; bus.MASK = mask;
    bus.QUIESCE_CYC = q; bus.PULSE_CYC = p; bus.RECOV_CYC = r;
    @(posedge CLK); #1;
    chk("busy_e0", {31'd0, bus.BUSY}, 32'd1);
    chk("clken_e0", {31'd0, bus.BANK_CLKEN}, 32'd0);
    chk("err_clear_e0", {31'd0, bus.ERR}, 32'd0);
    // Scramble operands after acceptance; the latched copy must be used.
    bus.PAT = ~pat; bus.MASK = '1;
    bus.QUIESCE_CYC = '1; bus.PULSE_CYC = '1; bus.RECOV_CYC = '1;

    s_seen = '1; r_seen = '1; pulses = 0; got = 1'b0; ack_k = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge CLK); #1;
      if ((bus.BANK_SETN != '1) || (bus.BANK_RN != '1)) begin
        pulses++;
        s_seen = bus.BANK_SETN;
        r_seen = bus.BANK_RN;
      end
      if (bus.ACK === 1'b1) begin
        got = 1'b1;
        ack_k = k;
      end
      if (k == drop_at) bus.REQ = 1'b0;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    e = sb.pop_front();
    if (got) begin
      chk("ack_edge", ack_k, e.ack_at);
      chk("pulse_cycles", pulses, e.pulses);
      chk("pulse_setn", {24'd0, s_seen}, {24'd0, e.setn});
      chk("pulse_rn", {24'd0, r_seen}, {24'd0, e.rn});
      chk("bank_q", {24'd0, bus.BANK_Q}, {24'd0, e.q});
      chk("err", {31'd0, bus.ERR}, {31'd0, e.err});
      chk("busy_ack", {31'd0, bus.BUSY}, 32'd0);
      chk("clken_ack", {31'd0, bus.BANK_CLKEN}, 32'd1);
    end
    for (int h = 0; h < hold_cyc; h++) begin
      @(posedge CLK); #1;
      chk("ack_hold", {31'd0, bus.ACK}, 32'd1);
      chk("no_reaccept", {31'd0, bus.BUSY}, 32'd0);
    end
    bus.REQ = 1'b0;
    @(posedge CLK); #1;
    chk("ack_fall", {31'd0, bus.ACK}, 32'd0);
  endtask

  initial begin
    RN = 1'b0;
    bus.REQ = 1'b0; bus.PAT = '0; bus.MASK = '0;
    bus.QUIESCE_CYC = '0; bus.PULSE_CYC = '0; bus.RECOV_CYC = '0;
    preload(8'h00);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_setn", {24'd0, bus.BANK_SETN}, 32'hFF);
    chk("rst_rn", {24'd0, bus.BANK_RN}, 32'hFF);
    chk("rst_clken", {31'd0, bus.BANK_CLKEN}, 32'd1);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_ack", {31'd0, bus.ACK}, 32'd0);
    chk("rst_err", {31'd0, bus.ERR}, 32'd0);
    @(negedge CLK); RN = 1'b1;

    // Basic load, partial mask, zero counts.
    preload(8'h00);
    do_load(8'hA5, 8'hFF, 4'd2, 4'd2, 4'd2, 0, 0);
    preload(8'h00);
    do_load(8'hFF, 8'h0F, 4'd1, 4'd2, 4'd1, 0, 0);
    do_load(8'h3C, 8'hFF, 4'd0, 4'd0, 4'd0, 0, 0);

    // Stuck-at-0 bit 3: ERR sets, holds, then clears at the next acceptance.
    stuck0 = 8'h08;
    preload(8'h00);
    do_load(8'h08, 8'h08, 4'd1, 4'd1, 4'd1, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("err_hold", {31'd0, bus.ERR}, 32'd1);
    do_load(8'hFF, 8'h00, 4'd1, 4'd1, 4'd1, 0, 0);
    stuck0 = 8'h00;

    // REQ dropped mid-PULSE, then REQ held across ACKW.
    do_load(8'h55, 8'hFF, 4'd2, 4'd3, 4'd1, 3, 0);
    do_load(8'hAA, 8'hF0, 4'd1, 4'd1, 4'd1, 0, 3);

    // Reset asserted asynchronously while pulse lines are low.
    preload(8'h00);
    @(negedge CLK);
    bus.REQ = 1'b1; bus.PAT = 8'hF0; bus.MASK = 8'hFF;
    bus.QUIESCE_CYC = 4'd1; bus.PULSE_CYC = 4'd8; bus.RECOV_CYC = 4'd1;
    repeat (3) @(posedge CLK);
    #3;
    chk("mid_pulse_setn", {24'd0, bus.BANK_SETN}, 32'h0F);
    RN = 1'b0;
    #1;
    chk("arst_setn", {24'd0, bus.BANK_SETN}, 32'hFF);
    chk("arst_rn", {24'd0, bus.BANK_RN}, 32'hFF);
    chk("arst_clken", {31'd0, bus.BANK_CLKEN}, 32'd1);
    chk("arst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("arst_ack", {31'd0, bus.ACK}, 32'd0);
    bus.REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RN = 1'b1;

    preload(8'h00);
    do_load(8'h81, 8'hFF, 4'd1, 4'd1, 4'd1, 0, 0);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
